// File: rtl/pipe_flow_pkg.sv
// Shared defaults and sizing helpers for the pipe_flow_ctrl block.
// Latency: n/a (constants and elaboration-time functions only).
// Backpressure: n/a.
package pipe_flow_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_LATENCY = 2;
    localparam int DEF_DEPTH   = 4;

    // Pointer width for a DEPTH-entry ring; a single entry still needs one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Count width must represent 0..DEPTH inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef logic [ptr_w(DEF_DEPTH)-1:0] def_ptr_t;
    typedef logic [cnt_w(DEF_DEPTH)-1:0] def_cnt_t;

endpackage

// File: rtl/pipe_flow_fifo.sv
// Result FIFO, DEPTH x WIDTH, pointers wrap modulo DEPTH (any DEPTH, not only powers of two).
// Latency: a push becomes visible at o_head the cycle after it is written.
// Backpressure: none internally; the caller guarantees no push when full and no pop when empty.
module pipe_flow_fifo
    import pipe_flow_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_push,
    input  logic [WIDTH-1:0]          i_push_dat,
    input  logic                      i_pop,
    output logic [WIDTH-1:0]          o_head,
    output logic [cnt_w(DEPTH)-1:0]   o_count,
    output logic                      o_empty
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Pointer and occupancy bookkeeping; storage itself is never cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Data storage write port.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_push_dat;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/pipe_flow_ctrl.sv
// Credit-based valid/ready wrapper around a fixed-latency, non-stallable pipeline (PIPE_FLOW_CTRL_BYPASS_EN = cut-through output).
// Latency: accept to out_valid is LATENCY+1 cycles, or LATENCY with PIPE_FLOW_CTRL_BYPASS_EN defined.
// Backpressure: in_ready drops once in-flight plus buffered results reach DEPTH; a pop frees a credit the next cycle.
module pipe_flow_ctrl
    import pipe_flow_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int LATENCY = DEF_LATENCY,
    parameter int DEPTH   = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] pipe_a,
    output logic [WIDTH-1:0] pipe_b,
    input  logic [WIDTH-1:0] pipe_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_c
);

    localparam int CNT_W = cnt_w(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + LATENCY + 1) + 1;

    // Every in-flight result must have a guaranteed FIFO slot, otherwise the pipeline could overrun it.
    generate
        if (DEPTH < LATENCY + 1) begin : g_bad_depth
            $error("pipe_flow_ctrl: DEPTH must be at least LATENCY+1");
        end
    endgenerate

    logic [LATENCY-1:0] r_vld;
    logic               r_in_ready;

    logic               w_accept;
    logic               w_arrive;
    logic               w_push;
    logic               w_pop;
    logic               w_out_vld;
    logic [WIDTH-1:0]   w_out_dat;
    logic [WIDTH-1:0]   w_fifo_head;
    logic [CNT_W-1:0]   w_fifo_cnt;
    logic               w_fifo_empty;
    logic [LATENCY-1:0] w_vld_nxt;
    logic [OCC_W-1:0]   w_pop_cnt;
    logic [OCC_W-1:0]   w_occ_nxt;

    assign w_accept = in_valid && r_in_ready;
    assign w_arrive = r_vld[LATENCY-1];
    assign pipe_a   = in_a;
    assign pipe_b   = in_b;

`ifdef PIPE_FLOW_CTRL_BYPASS_EN
    // An arriving result goes straight out when nothing older is queued; it is parked only if refused.
    assign w_out_vld = !w_fifo_empty || w_arrive;
    assign w_out_dat = w_fifo_empty ? pipe_c : w_fifo_head;
    assign w_push    = w_arrive && !(w_fifo_empty && out_ready);
    assign w_pop     = !w_fifo_empty && out_ready;
`else
    assign w_out_vld = !w_fifo_empty;
    assign w_out_dat = w_fifo_head;
    assign w_push    = w_arrive;
    assign w_pop     = !w_fifo_empty && out_ready;
`endif

    assign out_valid = w_out_vld;
    assign out_c     = w_out_vld ? w_out_dat : '0;
    assign in_ready  = r_in_ready;

    // Next valid-shift state and the occupancy it implies, used to register the credit decision.
    always_comb begin
        w_vld_nxt    = '0;
        w_vld_nxt[0] = w_accept;
        for (int i = 1; i < LATENCY; i++) begin
            w_vld_nxt[i] = r_vld[i-1];
        end
        w_pop_cnt = '0;
        for (int i = 0; i < LATENCY; i++) begin
            w_pop_cnt = w_pop_cnt + OCC_W'(w_vld_nxt[i]);
        end
        w_occ_nxt = w_pop_cnt + OCC_W'(w_fifo_cnt) + OCC_W'(w_push) - OCC_W'(w_pop);
    end

    // Valid tracking and registered credit; in_ready never sees out_ready or in_valid combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld      <= '0;
            r_in_ready <= 1'b0;
        end else begin
            r_vld      <= w_vld_nxt;
            r_in_ready <= (w_occ_nxt < OCC_W'(DEPTH));
        end
    end

    pipe_flow_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_push_dat (pipe_c),
        .i_pop      (w_pop),
        .o_head     (w_fifo_head),
        .o_count    (w_fifo_cnt),
        .o_empty    (w_fifo_empty)
    );

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Directed and randomized bench for pipe_flow_ctrl with an a+b two-stage pipeline attached.
// Latency: checks accept-to-output of 3 cycles (2 with PIPE_FLOW_CTRL_BYPASS_EN).
// Backpressure: exercises credit exhaustion, credit return timing and output hold under stall.
module tb_pipe_flow_ctrl;

    localparam int W = 32;
    localparam int L = 2;
    localparam int D = 4;
`ifdef PIPE_FLOW_CTRL_BYPASS_EN
    localparam int LAT_OUT = 2;
`else
    localparam int LAT_OUT = 3;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [W-1:0] pipe_a;
    logic [W-1:0] pipe_b;
    logic [W-1:0] pipe_c;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_c;

    logic [W-1:0] r_p1;
    logic [W-1:0] r_p2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Attached fixed-latency pipeline: captures every cycle, result two edges later.
    always_ff @(posedge clk) begin
        r_p1 <= pipe_a + pipe_b;
        r_p2 <= r_p1;
    end
    assign pipe_c = r_p2;

    pipe_flow_ctrl #(.WIDTH(W), .LATENCY(L), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .pipe_a    (pipe_a),
        .pipe_b    (pipe_b),
        .pipe_c    (pipe_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_q[$];
        logic [31:0] sum;
        int          n_acc;
        int          k;
        int          got;
        int          first;
        int          last;
        int          stalls;
        logic        prev_hold;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;

        // Reset state
        repeat (3) nxt();
        #1;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_c", out_c, 0);
        nxt(); rst = 1'b0; #1;
        chk("rel_in_ready_same", 32'(in_ready), 0);
        nxt(); #1;
        chk("rel_in_ready_rise", 32'(in_ready), 1);
        chk("rel_out_valid", 32'(out_valid), 0);

        // Single transaction latency: 1+2
        nxt(); in_valid = 1'b1; in_a = 1; in_b = 2; out_ready = 1'b1; #1;
        chk("pipe_a", pipe_a, 1);
        chk("pipe_b", pipe_b, 2);
        chk("lat_in_ready", 32'(in_ready), 1);
        for (int m = 1; m <= 4; m++) begin
            nxt(); in_valid = 1'b0; #1;
            chk("lat_out_valid", 32'(out_valid), 32'(m == LAT_OUT));
            if (m == LAT_OUT) chk("lat_out_c", out_c, 3);
        end
        repeat (3) nxt();

        // Credit exhaustion with downstream stalled
        out_ready = 1'b0;
        n_acc = 0;
        for (int j = 0; j < 6; j++) begin
            nxt(); in_valid = 1'b1; in_a = 32'(j); in_b = 10; #1;
            chk("fill_in_ready", 32'(in_ready), 32'(j < 4));
            if (in_valid && in_ready) n_acc++;
        end
        chk("fill_accepts", 32'(n_acc), 4);
        for (int j = 0; j < 4; j++) begin
            nxt(); in_valid = 1'b0; #1;
            chk("hold_out_valid", 32'(out_valid), 1);
            chk("hold_out_c", out_c, 10);
            chk("hold_in_ready", 32'(in_ready), 0);
        end

        // Drain in order; credit returns one cycle after the first pop
        nxt(); out_ready = 1'b1; #1;
        for (int m = 0; m <= 4; m++) begin
            if (m > 0) begin
                nxt(); #1;
            end
            chk("drain_out_valid", 32'(out_valid), 32'(m < 4));
            if (m < 4) chk("drain_out_c", out_c, 32'(10 + m));
            chk("drain_in_ready", 32'(in_ready), 32'(m >= 1));
        end

        // Sustained throughput, a=b=k
        k = 0; got = 0; first = -1; last = -1; stalls = 0;
        for (int c = 0; c < 200 && got < 100; c++) begin
            nxt(); in_valid = (k < 100); in_a = 32'(k); in_b = 32'(k); #1;
            if (in_valid && !in_ready) stalls++;
            if (in_valid && in_ready) begin
                exp_q.push_back(32'(2 * k));
                k++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() != 0) chk("thru_out_c", out_c, exp_q.pop_front());
                else chk("thru_extra", 32'(out_valid), 0);
                got++;
                if (first < 0) first = c;
                last = c;
            end
        end
        chk("thru_count", 32'(got), 100);
        chk("thru_no_gap", 32'(last - first), 99);
        chk("thru_no_stall", 32'(stalls), 0);
        nxt(); in_valid = 1'b0;
        repeat (3) nxt();

        // Reset with two results in flight and two buffered
        out_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            nxt(); in_valid = 1'b1; in_a = 32'(50 + j); in_b = 0; #1;
            chk("mid_fill_in_ready", 32'(in_ready), 1);
        end
        nxt(); in_valid = 1'b0; rst = 1'b1; #1;
        chk("mid_pre_out_valid", 32'(out_valid), 1);
        chk("mid_pre_out_c", out_c, 50);
        chk("mid_pre_in_ready", 32'(in_ready), 0);
        nxt(); rst = 1'b0; out_ready = 1'b1; #1;
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        chk("mid_rst_out_c", out_c, 0);
        chk("mid_rst_in_ready", 32'(in_ready), 0);
        for (int j = 0; j < 8; j++) begin
            nxt(); #1;
            chk("mid_stale", 32'(out_valid), 0);
            if (j == 0) chk("mid_in_ready", 32'(in_ready), 1);
        end

        // Random valid/ready with scoreboard
        exp_q.delete();
        prev_hold = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            nxt();
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_a      = $urandom;
            in_b      = $urandom;
            #1;
            if (prev_hold) begin
                chk("rnd_hold_valid", 32'(out_valid), 1);
                if (exp_q.size() != 0) chk("rnd_hold_c", out_c, exp_q[0]);
            end
            if (in_valid && in_ready) begin
                sum = in_a + in_b;
                exp_q.push_back(sum);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() != 0) chk("rnd_out_c", out_c, exp_q.pop_front());
                else chk("rnd_extra", 32'(out_valid), 0);
            end
            if (in_valid && in_ready) chk("rnd_no_ovf", 32'(exp_q.size() <= D), 1);
            prev_hold = out_valid && !out_ready;
        end
        nxt(); in_valid = 1'b0; out_ready = 1'b1; #1;
        for (int c = 0; c < 10; c++) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() != 0) chk("rnd_drain_c", out_c, exp_q.pop_front());
                else chk("rnd_drain_extra", 32'(out_valid), 0);
            end
            nxt(); #1;
        end
        chk("rnd_drain_empty", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_flow_ctrl.md
PIPE_FLOW_CTRL -- requirements
Module: pipe_flow_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: operand and result bit width.
REQ-002 Parameter LATENCY, default 2: fixed cycle count from operands on pipe_a/pipe_b to result on pipe_c of the attached non-stallable pipeline.
REQ-003 Parameter DEPTH, default 4: result FIFO entries and credit limit; elaboration error unless DEPTH >= LATENCY+1.
REQ-004 clk  input  1  sole clock, all state updates on posedge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 in_valid  input  1  upstream operand pair valid.
REQ-007 in_ready  output  1  block accepts operand pair this cycle.
REQ-008 in_a, in_b  input  WIDTH  upstream operands.
REQ-009 pipe_a, pipe_b  output  WIDTH  operands to the fixed-latency pipeline.
REQ-010 pipe_c  input  WIDTH  result from the fixed-latency pipeline.
REQ-011 out_valid  output  1  downstream result valid.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 out_c  output  WIDTH  result to downstream.

Function
REQ-014 Accept = in_valid && in_ready; pipe_a/pipe_b SHALL equal in_a/in_b combinationally every cycle (pipeline captures on the accept edge).
REQ-015 Valid shift register vld[LATENCY-1:0]: vld[0] <= accept, vld[i] <= vld[i-1]; pipe_c SHALL be treated as a valid result exactly in cycles where vld[LATENCY-1]=1.
REQ-016 Occupancy = popcount(vld) + fifo_count; in_ready SHALL be (occupancy < DEPTH), from registered state only, no combinational path from out_ready or in_valid.
REQ-017 A pop in the same cycle SHALL NOT raise in_ready that cycle; the credit returns the following cycle.
REQ-018 Arriving valid pipe_c SHALL be written to the FIFO tail unless bypassed (REQ-028); FIFO overflow SHALL be impossible by REQ-016.
REQ-019 out_valid = (fifo_count != 0); out_c = FIFO head; pop when out_valid && out_ready.
REQ-020 Simultaneous push and pop: fifo_count unchanged; push into an empty FIFO becomes visible next cycle.
REQ-021 Read/write pointers SHALL wrap modulo DEPTH; results leave in acceptance order, never dropped or duplicated.
REQ-022 out_c and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-023 Default latency accept-to-out_valid: LATENCY+1 cycles; sustained throughput one result per cycle when out_ready held high.

Reset
REQ-024 While rst=1: vld all 0, FIFO pointers and fifo_count 0; in_ready=0, out_valid=0, out_c=0 (data storage not cleared).
REQ-025 in_ready SHALL rise the first cycle after rst deasserts.
REQ-026 Reset mid-operation SHALL discard all in-flight and buffered results; pipe_c values arriving after reset are ignored because vld is cleared.

Configuration
REQ-027 Macro PIPE_FLOW_CTRL_BYPASS_EN selects cut-through output.
REQ-028 Defined: when FIFO empty and vld[LATENCY-1]=1, out_valid=1 and out_c=pipe_c in that cycle; if out_ready, no FIFO write; else written normally; latency becomes LATENCY.
REQ-029 Undefined: out_valid/out_c driven only from FIFO state (REQ-019).

Structure
REQ-030 Shared package pipe_flow_pkg SHALL hold the default WIDTH/LATENCY/DEPTH constants and the pointer/count width function clog2-based typedefs.
REQ-031 One sub-module, pipe_flow_fifo (DEPTH x WIDTH, push/pop/count), instantiated once; valid tracking and credits stay in the top.

Verification (LATENCY=2, DEPTH=4, pipeline modeled as a+b)
REQ-032 Reset then accept a=1,b=2, out_ready=1 -> out_valid high with out_c=3 exactly 3 cycles after accept (2 with bypass macro).
REQ-033 out_ready=0, in_valid=1 for 6 cycles with a=k,b=10 -> exactly 4 accepted, in_ready low thereafter, FIFO holds 10,11,12,13.
REQ-034 Then out_ready=1 -> outputs 10,11,12,13 in order on consecutive cycles; in_ready returns one cycle after first pop.
REQ-035 Continuous in_valid/out_ready for 100 cycles, a=k,b=k -> 100 results 2k, one per cycle, no gaps after fill.
REQ-036 rst pulsed one cycle with 2 results in flight and 2 buffered -> out_valid=0 next cycle, no stale result ever emitted.
REQ-037 Random in_valid/out_ready 50% for 10k cycles -> scoreboard order match, no overflow, out_c stable under back-pressure.
